shared_adder_scheduler: RTL and testbench
=========================================

Name: shared_adder_scheduler

Overview:
- Time-shares one unsigned adder between NREQ requesters, each presenting an operand pair (a, b).
- A round-robin arbiter selects one valid requester, steers its operands through the operand muxes into the shared adder, and registers the sum with the winner's id.
- A one-deep output slot with valid/ready handshake returns the result.
- Sits between operand producers and a single sum consumer; generalises the m-select a+b / c+d sharing scheme to N requesters and W bits.

Parameters:
- NREQ, 2, number of requesters (2..8).
- W, 4, operand width in bits.
- IDW, clog2(NREQ) (min 1), width of requester id.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  bit i: requester i presents an operand pair.
- req_ready  out  NREQ  bit i: pair i accepted this cycle (one-hot or zero).
- op_a  in  NREQ*W  operand a; requester i occupies bits [i*W +: W].
- op_b  in  NREQ*W  operand b, same packing.
- rsp_valid  out  1  output slot holds a result.
- rsp_ready  in  1  consumer takes the result.
- rsp_sum  out  W+1  a+b of the granted pair; MSB is carry.
- rsp_id  out  IDW  index of the requester that produced rsp_sum.
- busy  out  1  rsp_valid OR any req_valid.

Behaviour:
- Reset (rst=1 at clk edge): rsp_valid=0, rsp_sum=0, rsp_id=0, last_id=NREQ-1. req_ready=0 combinationally while rst=1.
- Slot FSM: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - can_accept = EMPTY OR (FULL AND rsp_ready).
- Arbitration: winner g = first i with req_valid[i]=1, searching last_id+1, last_id+2, … modulo NREQ. req_ready[g] = can_accept AND any req_valid AND NOT rst. All other req_ready bits are 0.
- Accept (req_valid[g] AND req_ready[g] at an edge):
  - rsp_sum <= zero_ext(op_a[g]) + zero_ext(op_b[g]), width W+1, no overflow possible.
  - rsp_id <= g; last_id <= g; rsp_valid <= 1.
  - Latency: result visible one cycle after accept.
- Drain without accept (FULL, rsp_ready=1, no req_valid): rsp_valid <= 0. rsp_sum and rsp_id hold their last value.
- Simultaneous drain and accept: slot reloads with the new result and rsp_valid stays 1. Full throughput of one sum per cycle.
- FULL with rsp_ready=0: rsp_sum, rsp_id and rsp_valid hold; all req_ready=0 (backpressure).
- last_id changes only on accept. A requester holding req_valid is granted within NREQ accepts (no starvation).
- Requesters must hold op_a/op_b stable while req_valid=1 and not accepted. The block samples operands only on the accept edge.
- req_valid deasserting without acceptance is legal. No state change results.
- Reset mid-operation: a pending result is discarded and not delivered. The first grant after reset goes to the lowest-index valid requester.
- NREQ=1: arbiter degenerates to pass-through; rsp_id constant 0.

Decomposition:
- Shared package: default NREQ/W constants, id-width function (clog2 with min 1), operand slice helper.
- Sub-module rr_arbiter:
  - parameter NREQ
  - inputs: req vector, last_id, enable
  - outputs: one-hot grant, encoded index
  - purely combinational
- Operand mux and W+1-bit add stay inline in the top.

Test Plan:
- After reset with NREQ=2, W=4: req_valid=2'b11, op_a={4'd3,4'd15}, op_b={4'd5,4'd1}, rsp_ready=1 -> cycle 1: rsp_sum=5'd16, rsp_id=0. Cycle 2: rsp_sum=5'd8, rsp_id=1. Grants alternate 0,1,0,1 while both stay valid.
- Backpressure: rsp_ready=0 after first accept (7+9) -> rsp_sum=5'd16 held, req_ready=2'b00 for 5 cycles. rsp_ready=1 -> next accept the same cycle, slot reloads, rsp_valid never drops.
- Single requester: only req_valid[1], a=4'hF, b=4'hF -> rsp_sum=5'h1E, rsp_id=1. Back-to-back accepts every cycle with rsp_ready=1.
- Drain to empty: one accept, then req_valid=0, rsp_ready=1 -> rsp_valid falls one cycle after the result appears; busy=0 thereafter.
- Reset mid-operation: rst=1 while FULL -> next cycle rsp_valid=0, req_ready=0 during rst. First grant after reset goes to requester 0 with both valid.
- NREQ=4 fairness: all four valid for 12 accepts -> rsp_id sequence 0,1,2,3 repeated three times. Drop req_valid[2] -> sequence 0,1,3.

Source files
------------

// File: rtl/shared_adder_scheduler_pkg.sv
// Shared types, defaults and helpers for the shared adder scheduler.
package shared_adder_scheduler_pkg;

    localparam int DEF_NREQ = 2;
    localparam int DEF_W    = 4;

    // Output slot occupancy: EMPTY means rsp_valid is low, FULL means a sum is waiting.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Requester id width: clog2(n), but never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Lowest bit of requester idx's operand inside a packed NREQ*W bus.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/shared_adder_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after last_id, wrapping modulo NREQ.
module shared_adder_scheduler_rr_arbiter
    import shared_adder_scheduler_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_id_i,
    input  logic            enable_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  grant_idx_o
);

    logic found;
    int   idx;

    // Rotating priority search starting one past the previous winner.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_id_i) + k) % NREQ;
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_idx_o  = IDW'(idx);
                grant_o[idx] = enable_i;
            end
        end
    end

endmodule

// File: rtl/shared_adder_scheduler.sv
// Time-shares one unsigned W-bit adder between NREQ requesters through a
// round-robin arbiter and a one-deep valid/ready result slot.
module shared_adder_scheduler
    import shared_adder_scheduler_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req_valid_i,
    output logic [NREQ-1:0]  req_ready_o,
    input  logic [NREQ*W-1:0] op_a_i,
    input  logic [NREQ*W-1:0] op_b_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [W:0]       rsp_sum_o,
    output logic [IDW-1:0]   rsp_id_o,
    output logic             busy_o
);

    slot_state_e      state_q;
    logic [W:0]       rsp_sum_q;
    logic [W:0]       rsp_sum_d;
    logic [IDW-1:0]   rsp_id_q;
    logic [IDW-1:0]   last_id_q;

    logic             can_accept;
    logic             accept;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic [W-1:0]     a_sel;
    logic [W-1:0]     b_sel;

    // The slot can take a new sum when empty, or when full and being drained this cycle.
    assign can_accept = (state_q == SLOT_EMPTY) || rsp_ready_i;

    shared_adder_scheduler_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i       (req_valid_i),
        .last_id_i   (last_id_q),
        .enable_i    (can_accept && !rst),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    // Grant is one-hot only when some requester is valid, so any grant bit is an accept.
    assign req_ready_o = grant;
    assign accept      = |grant;

    // Operand muxes feeding the single shared adder; carry lands in the MSB.
    always_comb begin
        a_sel     = op_a_i[slice_lo(int'(grant_idx), W) +: W];
        b_sel     = op_b_i[slice_lo(int'(grant_idx), W) +: W];
        rsp_sum_d = {1'b0, a_sel} + {1'b0, b_sel};
    end

    // Slot FSM: loads on accept, empties on a drain with nothing new to load.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q   <= SLOT_EMPTY;
            rsp_sum_q <= '0;
            rsp_id_q  <= '0;
            last_id_q <= IDW'(NREQ - 1);
        end else begin
            case (state_q)
                SLOT_EMPTY: begin
                    if (accept) begin
                        rsp_sum_q <= rsp_sum_d;
                        rsp_id_q  <= grant_idx;
                        last_id_q <= grant_idx;
                        state_q   <= SLOT_FULL;
                    end
                end
                SLOT_FULL: begin
                    if (accept) begin
                        rsp_sum_q <= rsp_sum_d;
                        rsp_id_q  <= grant_idx;
                        last_id_q <= grant_idx;
                    end else if (rsp_ready_i) begin
                        state_q <= SLOT_EMPTY;
                    end
                end
                default: state_q <= SLOT_EMPTY;
            endcase
        end
    end

    assign rsp_valid_o = (state_q == SLOT_FULL);
    assign rsp_sum_o   = rsp_sum_q;
    assign rsp_id_o    = rsp_id_q;
    assign busy_o      = rsp_valid_o || (|req_valid_i);

endmodule

// File: tb/tb_shared_adder_scheduler.sv
// Directed bench for shared_adder_scheduler: a 2-requester and a 4-requester instance.
module tb_shared_adder_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // NREQ=2, W=4 instance
    logic [1:0] v2;
    logic [1:0] rdy2;
    logic [7:0] a2, b2;
    logic       rr2, rv2, busy2;
    logic [4:0] s2;
    logic [0:0] id2;

    // NREQ=4, W=4 instance
    logic [3:0]  v4;
    logic [3:0]  rdy4;
    logic [15:0] a4, b4;
    logic        rr4, rv4, busy4;
    logic [4:0]  s4;
    logic [1:0]  id4;

    int errors = 0;
    int checks = 0;

    shared_adder_scheduler #(.NREQ(2), .W(4)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (v2),
        .req_ready_o (rdy2),
        .op_a_i      (a2),
        .op_b_i      (b2),
        .rsp_valid_o (rv2),
        .rsp_ready_i (rr2),
        .rsp_sum_o   (s2),
        .rsp_id_o    (id2),
        .busy_o      (busy2)
    );

    shared_adder_scheduler #(.NREQ(4), .W(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (v4),
        .req_ready_o (rdy4),
        .op_a_i      (a4),
        .op_b_i      (b4),
        .rsp_valid_o (rv4),
        .rsp_ready_i (rr4),
        .rsp_sum_o   (s4),
        .rsp_id_o    (id4),
        .busy_o      (busy4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Move just past the next rising edge; registered outputs are stable here.
    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    // Wait for the falling edge so combinational outputs have settled.
    task automatic settle();
        @(negedge clk);
    endtask

    int seq4 [6] = '{0, 1, 3, 0, 1, 3};

    initial begin
        rst = 1'b1;
        v2 = '0; a2 = '0; b2 = '0; rr2 = 1'b0;
        v4 = '0; a4 = '0; b4 = '0; rr4 = 1'b0;
        edge_step();
        edge_step();

        // Reset state
        check("rst_valid", 32'(rv2), 32'd0);
        check("rst_sum",   32'(s2),  32'd0);
        check("rst_id",    32'(id2), 32'd0);
        check("rst_busy",  32'(busy2), 32'd0);
        v2 = 2'b11; rr2 = 1'b1;
        settle();
        check("rst_ready_low", 32'(rdy2), 32'd0);
        edge_step();

        // Alternating grants: req0 15+1=16, req1 3+5=8
        rst = 1'b0;
        a2 = {4'd3, 4'd15};
        b2 = {4'd5, 4'd1};
        settle();
        check("rr_first_ready", 32'(rdy2), 32'b01);
        edge_step();
        check("rr_valid0", 32'(rv2), 32'd1);
        check("rr_sum0",   32'(s2),  32'd16);
        check("rr_id0",    32'(id2), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            settle();
            check("rr_ready", 32'(rdy2), (k % 2 == 1) ? 32'b10 : 32'b01);
            edge_step();
            check("rr_id",  32'(id2), 32'(k % 2));
            check("rr_sum", 32'(s2),  (k % 2 == 1) ? 32'd8 : 32'd16);
            check("rr_valid", 32'(rv2), 32'd1);
        end

        // Drain to empty
        v2 = 2'b00;
        edge_step();
        check("drain_valid", 32'(rv2), 32'd0);
        check("drain_busy",  32'(busy2), 32'd0);

        // Backpressure: req0 7+9=16, req1 1+2=3; last winner was 1 so req0 goes first
        a2 = {4'd1, 4'd7};
        b2 = {4'd2, 4'd9};
        v2 = 2'b11;
        rr2 = 1'b0;
        edge_step();
        check("bp_valid", 32'(rv2), 32'd1);
        check("bp_sum",   32'(s2),  32'd16);
        check("bp_id",    32'(id2), 32'd0);
        for (int k = 0; k < 5; k++) begin
            settle();
            check("bp_ready_low", 32'(rdy2), 32'd0);
            edge_step();
            check("bp_sum_hold",   32'(s2),  32'd16);
            check("bp_valid_hold", 32'(rv2), 32'd1);
        end
        rr2 = 1'b1;
        settle();
        check("bp_release_ready", 32'(rdy2), 32'b10);
        edge_step();
        check("bp_reload_valid", 32'(rv2), 32'd1);
        check("bp_reload_sum",   32'(s2),  32'd3);
        check("bp_reload_id",    32'(id2), 32'd1);

        // Single requester 1: 15+15=30 every cycle
        v2 = 2'b10;
        a2 = {4'hF, 4'h0};
        b2 = {4'hF, 4'h0};
        for (int k = 0; k < 3; k++) begin
            settle();
            check("single_ready", 32'(rdy2), 32'b10);
            edge_step();
            check("single_sum",   32'(s2),  32'h1E);
            check("single_id",    32'(id2), 32'd1);
            check("single_valid", 32'(rv2), 32'd1);
        end

        // Drain: valid drops, sum/id hold
        v2 = 2'b00;
        edge_step();
        check("drain2_valid", 32'(rv2), 32'd0);
        check("drain2_sum",   32'(s2),  32'h1E);
        check("drain2_id",    32'(id2), 32'd1);
        check("drain2_busy",  32'(busy2), 32'd0);

        // Reset mid-operation: req0 2+3=5, req1 4+4=8
        a2 = {4'd4, 4'd2};
        b2 = {4'd4, 4'd3};
        v2 = 2'b11;
        rr2 = 1'b0;
        edge_step();
        check("midrst_pre_sum", 32'(s2),  32'd5);
        check("midrst_pre_id",  32'(id2), 32'd0);
        rst = 1'b1;
        settle();
        check("midrst_ready_low", 32'(rdy2), 32'd0);
        edge_step();
        check("midrst_valid", 32'(rv2), 32'd0);
        check("midrst_sum",   32'(s2),  32'd0);
        rst = 1'b0;
        rr2 = 1'b1;
        settle();
        check("postrst_ready", 32'(rdy2), 32'b01);
        edge_step();
        check("postrst_id",  32'(id2), 32'd0);
        check("postrst_sum", 32'(s2),  32'd5);
        v2 = 2'b00;

        // NREQ=4 fairness: a[i]=i+1, b[i]=2i -> sum 3i+1
        for (int i = 0; i < 4; i++) begin
            a4[i*4 +: 4] = 4'(i + 1);
            b4[i*4 +: 4] = 4'(2 * i);
        end
        v4 = 4'b1111;
        rr4 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            edge_step();
            check("fair4_id",  32'(id4), 32'(k % 4));
            check("fair4_sum", 32'(s4),  32'(3 * (k % 4) + 1));
        end
        v4 = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            edge_step();
            check("skip2_id",  32'(id4), 32'(seq4[k]));
            check("skip2_sum", 32'(s4),  32'(3 * seq4[k] + 1));
        end
        check("skip2_valid", 32'(rv4), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
